// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq
//   Buffers host commands in an 8-deep FIFO and issues them one per cycle to
//   an LCD controller while the controller is not busy. Issuing a Write
//   (4'h0) ends the command stream. The sequencer then waits for the
//   controller's done pulse and parks in a terminal FINISH state.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   host_cmd     [3:0] command code offered by the host
//   host_valid   host_cmd valid this cycle
//   host_ready   sequencer accepts host_cmd this cycle
//   busy         LCD controller busy (level); issue only while low
//   done         LCD controller frame write-out complete
//   cmd          [3:0] command to the controller; 4'hF (no-op) when idle
//   cmd_valid    one-cycle strobe qualifying cmd
//   cmd_count    [7:0] commands issued since reset, saturating at 255
//   err_illegal  sticky, set when a code 12-15 is handshaken
//   seq_done     high once the frame write-out has completed
module lcd_cmd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       busy,
    input  logic       done,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] cmd_count,
    output logic       err_illegal,
    output logic       seq_done
);

    typedef enum logic [1:0] {LOAD, RUN, WAIT_WR, FINISH} state_t;

    localparam logic [3:0] CMD_NOP   = 4'hF;
    localparam logic [3:0] CMD_WRITE = 4'h0;

    state_t     state;
    logic [3:0] mem [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic [3:0] count;

    logic       hs;
    logic       push;
    logic       pop;
    logic [3:0] head;

    // Ready comes from registered state only; a full FIFO refuses even when
    // a pop lands on the same edge.
    assign host_ready = !reset && (count <= 4'd7) && (state != FINISH);
    assign hs         = host_valid && host_ready;
    // Illegal codes complete the handshake but are never stored.
    assign push       = hs && (host_cmd < 4'd12);
    assign pop        = (state == RUN) && (count != 4'd0) && !busy;
    assign head       = mem[rd_ptr];

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            wr_ptr      <= 3'd0;
            rd_ptr      <= 3'd0;
            count       <= 4'd0;
            cmd         <= CMD_NOP;
            cmd_valid   <= 1'b0;
            cmd_count   <= 8'd0;
            err_illegal <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            // Controller decodes Write without cmd_valid, so idle must be NOP.
            cmd       <= CMD_NOP;
            cmd_valid <= 1'b0;

            if (pop) begin
                cmd       <= head;
                cmd_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 3'd1;
                if (cmd_count != 8'hFF) cmd_count <= cmd_count + 8'd1;
            end

            if (push) wr_ptr <= wr_ptr + 3'd1;

            unique case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: ;
            endcase

            if (hs && (host_cmd >= 4'd12)) err_illegal <= 1'b1;

            unique case (state)
                LOAD:    if (!busy) state <= RUN;
                RUN:     if (pop && (head == CMD_WRITE)) state <= WAIT_WR;
                WAIT_WR: if (done) begin
                             state    <= FINISH;
                             seq_done <= 1'b1;
                         end
                FINISH:  ;
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
module tb_lcd_cmd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] host_cmd = 4'h0;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       busy = 1'b1;
    logic       done = 1'b0;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [7:0] cmd_count;
    logic       err_illegal;
    logic       seq_done;

    lcd_cmd_seq dut (
        .clk        (clk),
        .reset      (reset),
        .host_cmd   (host_cmd),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .busy       (busy),
        .done       (done),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_count  (cmd_count),
        .err_illegal(err_illegal),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    // Reference model: a queue of pending commands plus phase flags.
    int q[$];
    bit m_running;   // first non-busy edge after reset seen
    bit m_wrote;     // Write issued, stream closed
    bit m_fin;       // done seen after Write
    int m_cmd   = 15;
    int m_vld   = 0;
    int m_cnt   = 0;
    int m_err   = 0;
    int m_seq   = 0;
    bit acc;         // last cycle's handshake per model

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic hv, input logic [3:0] hc,
                         input logic b, input logic d);
        bit rdy;
        int h;
        reset = r; host_valid = hv; host_cmd = hc; busy = b; done = d;
        rdy = !r && (q.size() < 8) && !m_fin;
        #1;
        chk("host_ready", host_ready, rdy);
        acc = hv && rdy;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_running = 0; m_wrote = 0; m_fin = 0;
            m_cmd = 15; m_vld = 0; m_cnt = 0; m_err = 0; m_seq = 0;
        end else begin
            m_cmd = 15; m_vld = 0;
            if (!m_running) begin
                if (!b) m_running = 1;
            end else if (!m_wrote && q.size() > 0 && !b) begin
                h = q.pop_front();
                m_cmd = h; m_vld = 1;
                if (m_cnt < 255) m_cnt++;
                if (h == 0) m_wrote = 1;
            end else if (m_wrote && !m_fin && d) begin
                m_fin = 1; m_seq = 1;
            end
            if (acc) begin
                if (hc >= 12) m_err = 1;
                else q.push_back(int'(hc));
            end
        end
        #1;
        chk("cmd",         cmd,         m_cmd);
        chk("cmd_valid",   cmd_valid,   m_vld);
        chk("cmd_count",   cmd_count,   m_cnt);
        chk("err_illegal", err_illegal, m_err);
        chk("seq_done",    seq_done,    m_seq);
    endtask

    // Hold the offer until the model says it was taken.
    task automatic send(input logic [3:0] c, input logic b);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b1, c, b, 1'b0);
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n, input logic b);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, b, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Whenever no command is strobed the bus must carry the no-op code.
    always @(negedge clk) begin
        if (started && !cmd_valid) chk("noop_idle", cmd, 4'hF);
    end

    initial begin
        do_reset();
        started = 1'b1;
        chk("rst_count", dut.count, 0);

        // Long busy: nothing issues until busy falls, then 1,5 back-to-back.
        send(4'h1, 1'b1);
        send(4'h5, 1'b1);
        idle(68, 1'b1);
        idle(5, 1'b0);
        chk("busy70_cnt", cmd_count, 2);

        // Fill to 8 under busy; the 9th waits for the first pop.
        do_reset();
        idle(1, 1'b0);
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b1);
        chk("full_ready", host_ready, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
        send(4'h9, 1'b0);
        idle(12, 1'b0);
        chk("fill_cnt", cmd_count, 9);

        // Illegal code dropped, sticky error, only 3 issued.
        do_reset();
        send(4'hC, 1'b0);
        send(4'h3, 1'b0);
        idle(6, 1'b0);
        chk("illegal_err", err_illegal, 1);
        chk("illegal_cnt", cmd_count, 1);

        // Write ends the stream; 2 stays queued; done finishes.
        do_reset();
        send(4'h7, 1'b0);
        send(4'h0, 1'b0);
        send(4'h2, 1'b0);
        idle(6, 1'b0);
        chk("write_cnt", cmd_count, 2);
        cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("write_seq", seq_done, 1);
        idle(4, 1'b0);
        chk("fin_ready", host_ready, 0);

        // Reset while three entries are pending in RUN.
        do_reset();
        idle(1, 1'b0);
        send(4'h4, 1'b1);
        send(4'h6, 1'b1);
        send(4'h8, 1'b1);
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("midrst_count", dut.count, 0);
        chk("midrst_cnt", cmd_count, 0);
        idle(8, 1'b0);
        chk("midrst_stale", cmd_count, 0);

        // Randomized traffic.
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                logic r, hv, b, d;
                logic [3:0] hc;
                r  = ($urandom_range(0, 149) == 0);
                hv = ($urandom_range(0, 2) != 0);
                hc = ($urandom_range(0, 24) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                b  = ($urandom_range(0, 3) == 0);
                d  = ($urandom_range(0, 7) == 0);
                cycle(r, hv, hc, b, d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  synchronous, active-high; clock clk.
REQ-003 SHALL: host_cmd  input  4  command code offered by host.
REQ-004 SHALL: host_valid  input  1  host_cmd valid this cycle.
REQ-005 SHALL: host_ready  output  1  sequencer can accept host_cmd this cycle.
REQ-006 SHALL: busy  input  1  busy from the LCD controller; commands are issued only while low.
REQ-007 SHALL: done  input  1  done from the LCD controller; marks frame write-out complete.
REQ-008 SHALL: cmd  output  4  command to the LCD controller.
REQ-009 SHALL: cmd_valid  output  1  one-cycle strobe qualifying cmd.
REQ-010 SHALL: cmd_count  output  8  commands issued since reset, saturating.
REQ-011 SHALL: err_illegal  output  1  sticky flag for a received code 12-15.
REQ-012 SHALL: seq_done  output  1  high once the frame write-out has completed.

Function
REQ-013 SHALL: buffer accepted commands in an 8-entry, 4-bit FIFO with wrap-around read/write pointers and a 4-bit occupancy count.
REQ-014 SHALL: host handshake = host_valid && host_ready at a rising edge; host_ready = (count < 8) && state != FINISH, driven from registered state only.
REQ-015 SHALL: when full, refuse the push even if a pop happens in the same cycle.
REQ-016 SHALL: on a handshaken code 12-15, drop it (never enqueue), set err_illegal, and still complete the handshake.
REQ-017 SHALL: implement states LOAD, RUN, WAIT_WR, FINISH.
REQ-018 SHALL: LOAD -> RUN on the first edge where busy==0; no command is issued in LOAD.
REQ-019 SHALL: in RUN, at an edge with FIFO non-empty and busy==0, pop the head, register cmd=head and cmd_valid=1 for exactly one cycle.
REQ-020 SHALL: issue back-to-back commands on consecutive cycles while the conditions of REQ-019 hold.
REQ-021 SHALL: push at edge E into an empty FIFO with busy low -> cmd_valid high from edge E+1 to E+2; there is no bypass path.
REQ-022 SHALL: when not issuing, drive cmd=4'hF (no-op) with cmd_valid=0, because the controller decodes Write (4'h0) without cmd_valid.
REQ-023 SHALL: issuing code 4'h0 (Write) moves RUN -> WAIT_WR; no further pops occur until reset.
REQ-024 SHALL: WAIT_WR -> FINISH on the first edge with done==1; seq_done=1 in FINISH.
REQ-025 SHALL: FINISH is terminal until reset; entries left in the FIFO are retained and never issued.
REQ-026 SHALL: push and pop in the same edge leave count unchanged and update both pointers.
REQ-027 SHALL: increment cmd_count on each issue, saturating at 255.
REQ-028 SHALL: treat busy as a plain level; a busy==1 at an edge in RUN stalls issue and is not an error.

Reset
REQ-029 SHALL: on reset: state=LOAD, FIFO empty, pointers=0, cmd=4'hF, cmd_valid=0, cmd_count=0, err_illegal=0, seq_done=0.
REQ-030 SHALL: while reset is high, host_ready=0.
REQ-031 SHALL: reset asserted mid-operation (any state) discard all FIFO contents and the issue in flight; cmd_valid=0 on the next cycle.

Verification
REQ-032 SHALL: busy=1 for 70 cycles, push 4'h1,4'h5 -> no cmd_valid until busy falls; then 4'h1 and 4'h5 on consecutive cycles; cmd_count=2.
REQ-033 SHALL: busy=0, push 9 commands back-to-back with busy forced high -> host_ready=0 after the 8th push; 9th not taken until the first pop.
REQ-034 SHALL: push 4'hC then 4'h3 -> err_illegal=1 stays set; only 4'h3 is issued; cmd_count=1.
REQ-035 SHALL: push 4'h7,4'h0,4'h2 with busy=0 -> 4'h7 then 4'h0 issued; 4'h2 never issued; cmd=4'hF afterwards; seq_done=1 one edge after done=1.
REQ-036 SHALL: idle cycles in RUN -> cmd==4'hF on every cycle cmd_valid==0, checked by an assertion over the whole run.
REQ-037 SHALL: assert reset while 3 entries are queued in RUN -> count=0, state=LOAD, cmd_count=0; no stale command issued after release.
